add4_core: RTL and testbench

- Unsigned 4-bit adder producing a full 5-bit sum (carry-out in the MSB).
- The sum output is purely combinational, for use in datapaths that sample it within the same clock cycle.
- A registered status side-channel (registered sum and flags) is clocked by the single system clock.
- Used as a leaf arithmetic block and as the reference adder in exhaustive self-check benches.

---
 rtl/add4_core.sv | 88 ++++++++
 tb/tb_add4_core.sv | 127 ++++++++++++
 2 files changed

// File: rtl/add4_core.sv
// add4_core: unsigned WIDTH-bit ripple-carry adder with a registered status
// side-channel.
//
// Ports:
//   ck      in   system clock; registered outputs update on the rising edge
//   rst     in   asynchronous active-high reset; clears all registered outputs
//   s       out  [WIDTH:0]   combinational sum a+b (carry-out in the MSB)
//   a, b    in   [WIDTH-1:0] unsigned operands
//   s_q     out  [WIDTH:0]   registered copy of s
//   cout_q  out  registered carry-out
//   ovf_q   out  registered signed overflow of a+b
//   zero_q  out  registered flag, low WIDTH bits of the sum are zero
//
// The sum path is a structural carry chain built from one full-adder cell
// per bit. It has no clock or reset dependency, so s can be sampled in the
// same cycle the operands change.

// One bit of the carry chain: generate/propagate full adder.
// Ports: a, b operand bits; ci carry in; s sum bit; co carry out.
module add4_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic g;
    logic p;

    assign g  = a & b;
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = g | (p & ci);
endmodule

module add4_core #(
    parameter int WIDTH = 4
) (
    input  logic             ck,
    input  logic             rst,
    output logic [WIDTH:0]   s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   s_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             zero_q
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_lo;
    logic             ovf;
    logic             zero;

    // Carry into bit 0 is tied low: plain unsigned add, no carry-in port.
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        add4_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum_lo[i]),
            .co (carry[i+1])
        );
    end

    assign s = {carry[WIDTH], sum_lo};

    // Signed overflow: operands share a sign and the result sign differs.
    assign ovf  = (a[MSB] == b[MSB]) && (sum_lo[MSB] != a[MSB]);
    assign zero = (sum_lo == '0);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            s_q    <= s;
            cout_q <= carry[WIDTH];
            ovf_q  <= ovf;
            zero_q <= zero;
        end
    end
endmodule

// File: tb/tb_add4_core.sv
// Directed bench for add4_core: reset state, combinational corners, flag
// vectors, asynchronous reset mid-run, latency, and a full operand sweep.
module tb_add4_core;
    logic       ck;
    logic       rst;
    logic [4:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] s_q;
    logic       cout_q;
    logic       ovf_q;
    logic       zero_q;

    int n_vec = 0;
    int n_err = 0;

    add4_core #(.WIDTH(4)) dut (
        .ck     (ck),
        .rst    (rst),
        .s      (s),
        .a      (a),
        .b      (b),
        .s_q    (s_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q),
        .zero_q (zero_q)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive operands between edges, capture on the next posedge, check flags.
    task automatic flag_vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                            input logic [4:0] es, input logic ec, input logic eo,
                            input logic ez);
        @(negedge ck);
        a = va;
        b = vb;
        @(posedge ck);
        #1;
        chk({tag, " s_q"},    s_q,    es);
        chk({tag, " cout_q"}, cout_q, ec);
        chk({tag, " ovf_q"},  ovf_q,  eo);
        chk({tag, " zero_q"}, zero_q, ez);
    endtask

    task automatic comb_vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                            input logic [4:0] es);
        a = va;
        b = vb;
        #1;
        chk(tag, s, es);
    endtask

    initial begin
        rst = 1'b1;
        a   = 4'd0;
        b   = 4'd0;
        #2;
        chk("rst s_q",    s_q,    5'd0);
        chk("rst cout_q", cout_q, 1'b0);
        chk("rst ovf_q",  ovf_q,  1'b0);
        chk("rst zero_q", zero_q, 1'b0);

        // Combinational corners while still in reset: s must not care about rst.
        comb_vec("comb 0+0",   4'd0,  4'd0,  5'd0);
        comb_vec("comb 15+1",  4'd15, 4'd1,  5'd16);
        comb_vec("comb 15+15", 4'd15, 4'd15, 5'd30);
        comb_vec("comb 5+10",  4'd5,  4'd10, 5'd15);
        chk("comb in rst s_q", s_q, 5'd0);

        @(negedge ck);
        rst = 1'b0;

        flag_vec("8+8",   4'd8,  4'd8,  5'd16, 1'b1, 1'b1, 1'b1);
        flag_vec("7+1",   4'd7,  4'd1,  5'd8,  1'b0, 1'b1, 1'b0);
        flag_vec("3+4",   4'd3,  4'd4,  5'd7,  1'b0, 1'b0, 1'b0);
        flag_vec("0+0",   4'd0,  4'd0,  5'd0,  1'b0, 1'b0, 1'b1);
        flag_vec("15+15", 4'd15, 4'd15, 5'd30, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges: registers clear, s keeps tracking.
        #2;
        rst = 1'b1;
        #1;
        chk("async rst s_q",    s_q,    5'd0);
        chk("async rst cout_q", cout_q, 1'b0);
        chk("async rst ovf_q",  ovf_q,  1'b0);
        chk("async rst zero_q", zero_q, 1'b0);
        chk("async rst s",      s,      5'd30);
        @(negedge ck);
        rst = 1'b0;
        @(posedge ck);
        #1;
        chk("post rst s_q",    s_q,    5'd30);
        chk("post rst cout_q", cout_q, 1'b1);

        // Latency: s follows at once, s_q waits for the next posedge.
        a = 4'd3;
        b = 4'd4;
        #1;
        chk("lat s",      s,   5'd7);
        chk("lat s_q old", s_q, 5'd30);
        @(posedge ck);
        #1;
        chk("lat s_q new", s_q, 5'd7);

        // Full sweep of {b,a}; expected from plain 5-bit addition.
        for (int i = 0; i < 256; i++) begin
            @(posedge ck);
            {b, a} = i[7:0];
            @(negedge ck);
            chk($sformatf("sweep %0d+%0d", a, b), s, {1'b0, a} + {1'b0, b});
        end
        chk("sweep end s", s, 5'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
